// File: rtl/xbar_in_port_requester.sv
// Crossbar input-port requester: buffers one ingress stream, requests the destination
// output from the wavefront arbiter, streams the granted packet, then releases.
module xbar_in_port_requester #(
    parameter logic [1:0]  PORT_ID    = 2'd0,
    parameter int unsigned DW         = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          req,
    output logic [DW-1:0] addr,
    input  logic [11:0]   answer,
    input  logic [3:0]    arb_r,
    output logic [2:0]    state,
    output logic          tx_valid,
    output logic [DW-1:0] tx_data,
    output logic          tx_last,
    input  logic          tx_ready,
    output logic          timeout_err
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = DW + 1;

    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_REQ  = 3'b001;
    localparam logic [2:0] ST_XFER = 3'b010;
    localparam logic [2:0] ST_REL  = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_XFER    = 3'd2,
        S_REL     = 3'd3,
        S_BACKOFF = 3'd4
    } fsm_e;

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_ready_q, in_ready_d;
    logic          push, pop;
    logic [EW-1:0] head_q, head_d;

    fsm_e          fsm_q, fsm_d;
    logic [2:0]    state_q, state_d;
    logic          req_q, req_d;
    logic [DW-1:0] addr_q, addr_d;
    logic          tx_valid_q, tx_valid_d;
    logic [DW-1:0] tx_data_q, tx_data_d;
    logic          tx_last_q, tx_last_d;
    logic          terr_q, terr_d;
    logic [7:0]    cnt_q, cnt_d;

    logic [1:0]    dest;
    logic [2:0]    ans_slice;
    logic          grant;

    assign in_ready    = in_ready_q;
    assign req         = req_q;
    assign addr        = addr_q;
    assign state       = state_q;
    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign tx_last     = tx_last_q;
    assign timeout_err = terr_q;

    // Ingress storage; head is visible one cycle after the push (no bypass).
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_last, in_data};
        end
    end

    always_comb begin
        push       = in_valid && in_ready_q;
        pop        = (fsm_q == S_XFER) && tx_valid_q && tx_ready;
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        wr_ptr_d   = wr_ptr_q + AW'(push);
        count_d    = count_q + CW'(push) - CW'(pop);
        in_ready_d = (count_d != CW'(FIFO_DEPTH));
        head_q     = mem_q[rd_ptr_q];
        // Next-cycle head: the incoming word when the FIFO drains to empty this cycle.
        head_d     = ((count_q - CW'(pop)) == '0) ? {in_last, in_data} : mem_q[rd_ptr_d];
    end

    always_comb begin
        dest      = addr_q[DW-1:DW-2];
        ans_slice = 3'(answer >> (32'd3 * 32'(dest)));
        grant     = ans_slice[2] && (ans_slice[1:0] == PORT_ID) && arb_r[dest];
    end

    always_comb begin
        fsm_d      = fsm_q;
        req_d      = req_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        tx_last_d  = tx_last_q;
        terr_d     = 1'b0;

        case (fsm_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    addr_d = head_q[DW-1:0];
                    req_d  = 1'b1;
                    cnt_d  = '0;
                    fsm_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (grant) begin
                    fsm_d      = S_XFER;
                    tx_valid_d = (count_d != '0);
                    tx_data_d  = head_d[DW-1:0];
                    tx_last_d  = head_d[DW];
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    terr_d = 1'b1;
                    req_d  = 1'b0;
                    cnt_d  = '0;
                    fsm_d  = S_BACKOFF;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_BACKOFF: begin
                req_d = 1'b1;
                fsm_d = S_REQ;
            end
            S_XFER: begin
                if (pop && tx_last_q) begin
                    req_d = 1'b0;
                    fsm_d = S_REL;
                end else begin
                    tx_valid_d = (count_d != '0);
                    tx_data_d  = head_d[DW-1:0];
                    tx_last_d  = head_d[DW];
                end
            end
            S_REL: begin
                fsm_d = S_IDLE;
            end
            default: begin
                req_d = 1'b0;
                fsm_d = S_IDLE;
            end
        endcase

        case (fsm_d)
            S_REQ:            state_d = ST_REQ;
            S_XFER:           state_d = ST_XFER;
            S_REL, S_BACKOFF: state_d = ST_REL;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            fsm_q      <= S_IDLE;
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            addr_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_last_q  <= 1'b0;
            terr_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_last_q  <= tx_last_d;
            terr_q     <= terr_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_xbar_in_port_requester.sv
// Scoreboard bench for xbar_in_port_requester (PORT_ID=1, short request timeout).
module tb_xbar_in_port_requester;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          req;
    logic [DW-1:0] addr;
    logic [11:0]   answer;
    logic [3:0]    arb_r;
    logic [2:0]    state;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_last;
    logic          tx_ready;
    logic          timeout_err;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int beats  = 0;
    logic [63:0] sb[$];
    logic [63:0] held;
    bit          stall = 1'b0;

    xbar_in_port_requester #(
        .PORT_ID    (2'd1),
        .DW         (DW),
        .FIFO_DEPTH (8),
        .TIMEOUT    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .req         (req),
        .addr        (addr),
        .answer      (answer),
        .arb_r       (arb_r),
        .state       (state),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d, input logic l);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) chk("push_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        sb.push_back({31'd0, l, d});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        for (int i = 0; i < 60 && state !== s; i++) tick();
        chk(tag, 64'(state), 64'(s));
    endtask

    // Runs until the last beat is accepted, then checks the release sequence.
    task automatic wait_last(input string tag, input bit toggle);
        bit found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tx_valid && tx_ready && tx_last) begin
                found = 1'b1;
                break;
            end
            if (toggle) tx_ready = !tx_ready;
            tick();
        end
        chk({tag, "_last_beat"}, 64'(found), 64'd1);
        tick();
        chk({tag, "_rel_state"}, 64'(state), 64'd4);
        chk({tag, "_rel_req"}, 64'(req), 64'd0);
        chk({tag, "_rel_txv"}, 64'(tx_valid), 64'd0);
        tick();
        chk({tag, "_idle_state"}, 64'(state), 64'd0);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    // Output monitor: accepted beats are matched in order against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            stall = 1'b0;
        end else begin
            if (stall && tx_valid) chk("tx_hold", 64'({tx_last, tx_data}), held);
            if (tx_valid && tx_ready) begin
                beats++;
                chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) chk("tx_word", 64'({tx_last, tx_data}), sb.pop_front());
            end
            stall = tx_valid && !tx_ready;
            held  = 64'({tx_last, tx_data});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int b0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        answer   = '0;
        arb_r    = '0;
        tx_ready = 1'b0;
        tick();
        tick();
        chk("rst_req", 64'(req), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_tx_last", 64'(tx_last), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_terr", 64'(timeout_err), 64'd0);
        reset = 1'b1;
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Granted 3-word packet to output 2.
        push_word(32'h8000_0003, 1'b0);
        push_word(32'h1111_1111, 1'b0);
        push_word(32'h2222_2222, 1'b1);
        chk("t1_req", 64'(req), 64'd1);
        chk("t1_addr", 64'(addr), 64'h8000_0003);
        chk("t1_state", 64'(state), 64'd1);
        answer   = 12'b000_101_000_000;
        arb_r    = 4'b0100;
        tx_ready = 1'b1;
        b0 = beats;
        wait_last("t1", 1'b0);
        chk("t1_beats", 64'(beats - b0), 64'd3);

        // Grant to another source: timeout, one-cycle backoff, re-request.
        answer = 12'b000_100_000_000;
        push_word(32'h8000_0004, 1'b0);
        tick();
        chk("t2_req_state", 64'(state), 64'd1);
        t0 = cyc;
        push_word(32'h3333_3333, 1'b0);
        push_word(32'h4444_4444, 1'b1);
        for (int i = 0; i < 20 && !timeout_err; i++) begin
            chk("t2_no_tx", 64'(tx_valid), 64'd0);
            tick();
        end
        chk("t2_terr", 64'(timeout_err), 64'd1);
        chk("t2_terr_cycles", 64'(cyc - t0), 64'd4);
        chk("t2_backoff_req", 64'(req), 64'd0);
        chk("t2_backoff_state", 64'(state), 64'd4);
        tick();
        chk("t2_rereq", 64'(req), 64'd1);
        chk("t2_rereq_state", 64'(state), 64'd1);
        chk("t2_terr_pulse", 64'(timeout_err), 64'd0);
        answer = 12'b000_101_000_000;
        wait_last("t2", 1'b0);

        // FIFO fill with no grant, rejected push at full, space after one pop.
        answer   = '0;
        arb_r    = '0;
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(32'h4000_0010 + 32'(i), 1'(i == 7));
        chk("t3_full", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_data  = 32'h0000_0BAD;
        in_last  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t3_still_full", 64'(in_ready), 64'd0);
        answer   = 12'b000_000_101_000;
        arb_r    = 4'b0010;
        tx_ready = 1'b1;
        for (int i = 0; i < 40 && !(tx_valid && tx_ready); i++) tick();
        tick();
        chk("t3_ready_after_pop", 64'(in_ready), 64'd1);
        wait_last("t3", 1'b0);

        // Backpressure toggling on the crossbar side.
        answer   = 12'b000_000_000_101;
        arb_r    = 4'b0001;
        tx_ready = 1'b0;
        b0 = beats;
        push_word(32'h0000_0020, 1'b0);
        push_word(32'hAAAA_0001, 1'b0);
        push_word(32'hAAAA_0002, 1'b0);
        push_word(32'hAAAA_0003, 1'b1);
        wait_last("t4", 1'b1);
        chk("t4_beats", 64'(beats - b0), 64'd4);

        // Reset during transfer drops the packet.
        tx_ready = 1'b0;
        push_word(32'h0000_0030, 1'b0);
        push_word(32'hBBBB_0001, 1'b0);
        push_word(32'hBBBB_0002, 1'b0);
        push_word(32'hBBBB_0003, 1'b1);
        wait_state(3'b010, "t5_xfer");
        tx_ready = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("t5_req", 64'(req), 64'd0);
        chk("t5_state", 64'(state), 64'd0);
        chk("t5_tx_valid", 64'(tx_valid), 64'd0);
        sb.delete();
        tick();
        reset = 1'b1;
        tick();
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        tick();
        tick();
        tick();
        chk("t5_empty_idle", 64'(state), 64'd0);
        chk("t5_empty_noreq", 64'(req), 64'd0);

        // Single-word packet to output 3; mismatched answers ignored first.
        answer = 12'b100_000_101_000;
        arb_r  = 4'b1010;
        b0 = beats;
        push_word(32'hC000_0000, 1'b1);
        tick();
        chk("t6_req_state", 64'(state), 64'd1);
        tick();
        chk("t6_ignore_state", 64'(state), 64'd1);
        chk("t6_ignore_tx", 64'(tx_valid), 64'd0);
        answer = 12'b101_000_000_000;
        arb_r  = 4'b1000;
        wait_last("t6", 1'b0);
        chk("t6_beats", 64'(beats - b0), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
